phase_to_sample: RTL and testbench

- Consumes the 24-bit operator phase produced by the phase accumulator and converts it into a signed 16-bit sine sample; it is the reader/consumer end of the phase interface.
- Adds a per-sample phase-modulation offset (FM input) before the lookup.
- Uses a quarter-wave sine ROM with quadrant folding.
- Samples are time-multiplexed across operators, tagged with an operator index, and pass through a 3-stage valid/ready pipeline toward the operator mixer.

---
 rtl/phase_to_sample.sv | 104 ++++++++++
 tb/tb_phase_to_sample.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_to_sample.sv
`timescale 1ns/1ps
// Phase-to-sample converter: adds a phase-modulation offset to an operator phase and
// looks up a signed 16-bit sine sample through a folded quarter-wave ROM (3-stage pipe).
module phase_to_sample #(
  parameter int TAG_WIDTH = 3,
  parameter     ROM_FILE  = "sine_quarter.hex"
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Valid,
  output logic                 o_Ready,
  input  logic [23:0]          i_Phase,
  input  logic [23:0]          i_Modulation,
  input  logic [TAG_WIDTH-1:0] i_Tag,
  output logic                 o_Valid,
  input  logic                 i_Ready,
  output logic [15:0]          o_Sample,
  output logic [TAG_WIDTH-1:0] o_Tag
);

  localparam real HALF_PI = 1.5707963267948966;

  // Quarter-wave table, sampled at half-step offsets so that mirroring the address
  // (~a) lands exactly on the reflected sample. Contents are fixed at elaboration and
  // match the image that ROM_FILE names for flows that load it externally.
  logic [14:0] rom [1024];

  genvar gi;
  generate
    for (gi = 0; gi < 1024; gi++) begin : g_rom
      localparam real ANGLE = HALF_PI * (gi + 0.5) / 1024.0;
      localparam int  VALUE = $rtoi(32767.0 * $sin(ANGLE) + 0.5);
      assign rom[gi] = 15'(VALUE);
    end
  endgenerate

  logic                 adv;
  logic [23:0]          phase_sum;
  logic [9:0]           rom_addr;
  logic [15:0]          mag_ext;
  logic [15:0]          sample_next;

  logic                 s1_valid_reg;
  logic [23:12]         s1_phase_reg;
  logic [TAG_WIDTH-1:0] s1_tag_reg;

  logic                 s2_valid_reg;
  logic [14:0]          s2_mag_reg;
  logic                 s2_neg_reg;
  logic [TAG_WIDTH-1:0] s2_tag_reg;

  logic                 out_valid_reg;
  logic [15:0]          sample_reg;
  logic [TAG_WIDTH-1:0] out_tag_reg;

  // The whole pipe moves together; a stalled output freezes every stage.
  assign adv     = !out_valid_reg || i_Ready;
  assign o_Ready = adv;

  assign phase_sum = i_Phase + i_Modulation;

  // Odd quadrants read the table backwards.
  assign rom_addr = s1_phase_reg[22] ? ~s1_phase_reg[21:12] : s1_phase_reg[21:12];

  assign mag_ext     = {1'b0, s2_mag_reg};
  assign sample_next = s2_neg_reg ? (~mag_ext + 16'd1) : mag_ext;

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      s1_valid_reg  <= 1'b0;
      s2_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      sample_reg    <= '0;
      out_tag_reg   <= '0;
    end else if (adv) begin
      s1_valid_reg  <= i_Valid;
      s2_valid_reg  <= s1_valid_reg;
      out_valid_reg <= s2_valid_reg;
      if (s2_valid_reg) begin
        sample_reg  <= sample_next;
        out_tag_reg <= s2_tag_reg;
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (adv) begin
      s1_phase_reg <= phase_sum[23:12];
      s1_tag_reg   <= i_Tag;
      s2_mag_reg   <= rom[rom_addr];
      s2_neg_reg   <= s1_phase_reg[23];
      s2_tag_reg   <= s1_tag_reg;
    end
  end

  assign o_Valid  = out_valid_reg;
  assign o_Sample = sample_reg;
  assign o_Tag    = out_tag_reg;

  // Fractional phase bits below the table resolution are truncated by design.
  logic unused_ok;
  assign unused_ok = ^{ROM_FILE, phase_sum[11:0]};

endmodule

// File: tb/tb_phase_to_sample.sv
`timescale 1ns/1ps
// Self-checking bench for phase_to_sample: table vectors, hand-written corner sequences
// and randomized traffic compared against a full-wave sine reference model.
module tb_phase_to_sample;

  localparam real PI = 3.14159265358979323846;

  logic        i_Clock;
  logic        i_Reset;
  logic        i_Valid;
  logic        o_Ready;
  logic [23:0] i_Phase;
  logic [23:0] i_Modulation;
  logic [2:0]  i_Tag;
  logic        o_Valid;
  logic        i_Ready;
  logic [15:0] o_Sample;
  logic [2:0]  o_Tag;

  phase_to_sample #(.TAG_WIDTH(3), .ROM_FILE("sine_quarter.hex")) dut (
    .i_Clock      (i_Clock),
    .i_Reset      (i_Reset),
    .i_Valid      (i_Valid),
    .o_Ready      (o_Ready),
    .i_Phase      (i_Phase),
    .i_Modulation (i_Modulation),
    .i_Tag        (i_Tag),
    .o_Valid      (o_Valid),
    .i_Ready      (i_Ready),
    .o_Sample     (o_Sample),
    .o_Tag        (o_Tag)
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         sample;
    logic [2:0] tag;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  int   adv_count = 0;
  int   delivered = 0;

  // Full-wave reference: 4096 phase steps per cycle, sampled at half-step centres.
  function automatic int ref_sample(input logic [23:0] p);
    real x;
    int  k;
    k = int'(p[23:12]);
    x = 32767.0 * $sin(2.0 * PI * (real'(k) + 0.5) / 4096.0);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  task automatic check_int(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic logic model_out_valid();
    return (exp_q.size() > 0) && (exp_q[0].due == adv_count);
  endfunction

  task automatic check_outputs();
    logic ev;
    ev = model_out_valid();
    check_int("o_Valid", int'(o_Valid), int'(ev));
    if (ev) begin
      check_int("o_Sample", int'($signed(o_Sample)), exp_q[0].sample);
      check_int("o_Tag", int'(o_Tag), int'(exp_q[0].tag));
    end
    if (o_Valid) check_int("no_min_value", int'(o_Sample == 16'h8000), 0);
  endtask

  // One clock: drive at the falling edge, check o_Ready, update the model at the rising
  // edge, then check outputs at the next falling edge.
  task automatic step(input logic v, input logic [23:0] ph, input logic [23:0] md,
                      input logic [2:0] tg, input logic rdy, output logic accepted);
    logic ev, eadv;
    exp_t e;
    i_Valid = v; i_Phase = ph; i_Modulation = md; i_Tag = tg; i_Ready = rdy;
    ev   = model_out_valid();
    eadv = !ev || rdy;
    #1;
    check_int("o_Ready", int'(o_Ready), int'(eadv));
    accepted = v && eadv;
    @(posedge i_Clock);
    if (eadv) begin
      if (ev) begin
        void'(exp_q.pop_front());
        delivered++;
      end
      if (accepted) begin
        e.sample = ref_sample(ph + md);
        e.tag    = tg;
        e.due    = adv_count + 3;
        exp_q.push_back(e);
      end
      adv_count++;
    end
    @(negedge i_Clock);
    check_outputs();
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 24'h0, 24'h0, 3'd0, 1'b1, acc);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1);
    check_int("drain_empty", exp_q.size(), 0);
  endtask

  typedef struct {
    logic [23:0] phase;
    logic [23:0] modu;
    logic [2:0]  tag;
    int          sample;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic [23:0] ph, md;
    logic [2:0]  tg;
    logic        pend;
    int          idx, stall_left, d0;
    logic [15:0] held_sample;
    logic [2:0]  held_tag;

    vecs[0] = '{24'h000000, 24'h000000, 3'd0, 25};
    vecs[1] = '{24'h400000, 24'h000000, 3'd1, 32767};
    vecs[2] = '{24'h800000, 24'h000000, 3'd2, -25};
    vecs[3] = '{24'hC00000, 24'h000000, 3'd3, -32767};
    vecs[4] = '{24'h3FF000, 24'h000000, 3'd4, 32767};
    vecs[5] = '{24'h3FFFFF, 24'h000000, 3'd5, 32767};
    vecs[6] = '{24'hF00000, 24'h200000, 3'd6, ref_sample(24'h100000)};
    vecs[7] = '{24'h100000, 24'hE00000, 3'd7, ref_sample(24'hF00000)};

    i_Reset = 1'b0; i_Valid = 1'b0; i_Ready = 1'b1;
    i_Phase = '0; i_Modulation = '0; i_Tag = '0;
    repeat (3) @(negedge i_Clock);
    check_int("reset_o_Valid", int'(o_Valid), 0);
    check_int("reset_o_Sample", int'(o_Sample), 0);
    check_int("reset_o_Tag", int'(o_Tag), 0);
    i_Reset = 1'b1;
    idle(2);

    // Table vectors: one input at a time, output expected exactly 3 clocks later.
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].phase, vecs[i].modu, vecs[i].tag, 1'b1, acc);
      check_int("vec_accepted", int'(acc), 1);
      idle(2);
      check_int($sformatf("vec%0d_valid", i), int'(o_Valid), 1);
      check_int($sformatf("vec%0d_sample", i), int'($signed(o_Sample)), vecs[i].sample);
      check_int($sformatf("vec%0d_tag", i), int'(o_Tag), int'(vecs[i].tag));
      idle(1);
      $display("vec %0d phase=%h mod=%h -> sample=%0d tag=%0d", i, vecs[i].phase,
               vecs[i].modu, vecs[i].sample, vecs[i].tag);
    end
    drain();

    // Back-pressure: 8 back-to-back phases, 5-cycle stall once output appears.
    d0 = delivered; idx = 0; stall_left = -1;
    held_sample = '0; held_tag = '0;
    for (int cyc = 0; cyc < 80 && (idx < 8 || exp_q.size() > 0); cyc++) begin
      logic rdy;
      if (stall_left < 0 && o_Valid) begin
        stall_left  = 5;
        held_sample = o_Sample;
        held_tag    = o_Tag;
      end
      rdy = !(stall_left > 0);
      ph  = 24'(idx * 24'h1A3000 + 24'h000800);
      step(idx < 8, ph, 24'h0, 3'(idx), rdy, acc);
      if (!rdy) begin
        check_int("stall_sample_held", int'(o_Sample), int'(held_sample));
        check_int("stall_tag_held", int'(o_Tag), int'(held_tag));
        stall_left--;
      end
      if (acc) idx++;
    end
    check_int("bp_accepted", idx, 8);
    check_int("bp_delivered", delivered - d0, 8);
    $display("backpressure: accepted=%0d delivered=%0d", idx, delivered - d0);

    // Continuous sweep over the whole phase circle.
    for (int i = 0; i < 4096; i++)
      step(1'b1, 24'(i * 24'h001000), 24'h0, 3'(i), 1'b1, acc);
    drain();
    $display("sweep: 4096 phases checked");

    // Randomized traffic with random modulation, gaps and back-pressure.
    pend = 1'b0; ph = '0; md = '0; tg = '0;
    for (int i = 0; i < 1500; i++) begin
      logic v;
      if (!pend) begin
        pend = ($urandom_range(0, 3) != 0);
        ph   = 24'($urandom);
        md   = 24'($urandom);
        tg   = 3'($urandom_range(0, 7));
      end
      v = pend;
      step(v, ph, md, tg, $urandom_range(0, 3) != 0, acc);
      if (acc) pend = 1'b0;
    end
    drain();
    $display("random: 1500 cycles checked, delivered total=%0d", delivered);

    // Asynchronous reset with samples in flight.
    step(1'b1, 24'h123000, 24'h0, 3'd1, 1'b1, acc);
    step(1'b1, 24'h456000, 24'h0, 3'd2, 1'b1, acc);
    step(1'b1, 24'h789000, 24'h0, 3'd3, 1'b1, acc);
    i_Valid = 1'b0;
    #2 i_Reset = 1'b0;
    #1;
    check_int("async_rst_o_Valid", int'(o_Valid), 0);
    check_int("async_rst_o_Sample", int'(o_Sample), 0);
    check_int("async_rst_o_Tag", int'(o_Tag), 0);
    exp_q.delete();
    repeat (2) @(negedge i_Clock);
    i_Reset = 1'b1;
    idle(6);
    step(1'b1, 24'h400000, 24'h0, 3'd5, 1'b1, acc);
    idle(2);
    check_int("post_rst_sample", int'($signed(o_Sample)), 32767);
    drain();
    $display("async reset: in-flight samples discarded");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
